// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
// Holds the state encoding and the one-hot decode helper used by the grant decoder.
package rr_arbiter4_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [NREQ-1:0] decode2to4(input logic [IDX_W-1:0] idx);
    decode2to4 = NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the four clients and the arbiter.
// Optional lock input present when RR_ARB_LOCK_EN is defined.
interface rr_arbiter4_if;
  import rr_arbiter4_pkg::*;

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             preempt;
`ifdef RR_ARB_LOCK_EN
  logic             lock;

  modport master (output req, output lock,
                  input gnt, input gnt_idx, input gnt_valid, input preempt);
  modport slave  (input req, input lock,
                  output gnt, output gnt_idx, output gnt_valid, output preempt);
`else
  modport master (output req,
                  input gnt, input gnt_idx, input gnt_valid, input preempt);
  modport slave  (input req,
                  output gnt, output gnt_idx, output gnt_valid, output preempt);
`endif

endinterface

// File: rtl/rr_arbiter4_decoder2to4.sv
// Registered-index to one-hot grant decoder; purely combinational, zero when disabled.
module rr_arbiter4_decoder2to4
  import rr_arbiter4_pkg::*;
(
  input  logic             i_en,
  input  logic [IDX_W-1:0] i_idx,
  output logic [NREQ-1:0]  o_onehot
);

  assign o_onehot = i_en ? decode2to4(i_idx) : '0;

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter, 1-cycle req-to-grant, grant held until release or hold timeout.
// Define RR_ARB_LOCK_EN to add a lock input that suppresses the timeout while granted.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter4_if.slave arb
);

  localparam logic [CNT_W-1:0] HOLD_LIM = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT = {CNT_W{1'b1}};

  state_e           r_state, w_state_n;
  logic [IDX_W-1:0] r_idx,   w_idx_n;
  logic [IDX_W-1:0] r_ptr,   w_ptr_n;
  logic [CNT_W-1:0] r_hold,  w_hold_n;
  logic             r_preempt, w_preempt_n;

  logic [IDX_W-1:0] w_win;
  logic             w_any_req;
  logic             w_owner_req;
  logic             w_others;
  logic             w_lock;
  logic             w_timeout;
  logic [NREQ-1:0]  w_gnt;

  // First requester at or after p, wrapping with natural 2-bit overflow.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] c;
    rr_pick = p;
    for (int k = NREQ - 1; k >= 0; k--) begin
      c = p + IDX_W'(k);
      if (r[c]) rr_pick = c;
    end
  endfunction

`ifdef RR_ARB_LOCK_EN
  assign w_lock = arb.lock;
`else
  assign w_lock = 1'b0;
`endif

  // ptr always equals owner+1 while granted, so one search serves release and timeout.
  assign w_win       = rr_pick(arb.req, r_ptr);
  assign w_any_req   = |arb.req;
  assign w_owner_req = arb.req[r_idx];
  assign w_others    = |(arb.req & ~decode2to4(r_idx));
  assign w_timeout   = (MAX_HOLD != 0) && (r_hold >= HOLD_LIM) && !w_lock;

  always_comb begin
    w_state_n   = r_state;
    w_idx_n     = r_idx;
    w_ptr_n     = r_ptr;
    w_hold_n    = r_hold;
    w_preempt_n = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_hold_n = '0;
        if (w_any_req) begin
          w_state_n = ST_GRANT;
          w_idx_n   = w_win;
          w_ptr_n   = w_win + IDX_W'(1);
        end
      end
      ST_GRANT: begin
        if (w_owner_req) begin
          if (w_timeout && w_others) begin
            w_idx_n     = w_win;
            w_ptr_n     = w_win + IDX_W'(1);
            w_hold_n    = '0;
            w_preempt_n = 1'b1;
          end else if (r_hold != HOLD_SAT) begin
            w_hold_n = r_hold + CNT_W'(1);
          end
        end else begin
          w_hold_n = '0;
          if (w_any_req) begin
            w_idx_n = w_win;
            w_ptr_n = w_win + IDX_W'(1);
          end else begin
            w_state_n = ST_IDLE;
          end
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_hold    <= '0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_idx     <= w_idx_n;
      r_ptr     <= w_ptr_n;
      r_hold    <= w_hold_n;
      r_preempt <= w_preempt_n;
    end
  end

  rr_arbiter4_decoder2to4 u_dec (
    .i_en     (r_state == ST_GRANT),
    .i_idx    (r_idx),
    .o_onehot (w_gnt)
  );

  assign arb.gnt       = w_gnt;
  assign arb.gnt_idx   = r_idx;
  assign arb.gnt_valid = (r_state == ST_GRANT);
  assign arb.preempt   = r_preempt;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed vector bench for rr_arbiter4 with MAX_HOLD=4; lock sequence runs when RR_ARB_LOCK_EN is defined.
module tb_rr_arbiter4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  rr_arbiter4_if arb ();

  rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .arb (arb)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       preempt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                     input logic [1:0] ix, input logic p);
    vec_t v;
    v.rst = r; v.req = rq; v.gnt = g; v.idx = ix; v.preempt = p;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] ix,
                         input logic p);
    chk({tag, " gnt"}, 32'(arb.gnt), 32'(g));
    chk({tag, " gnt_valid"}, 32'(arb.gnt_valid), 32'(|g));
    chk({tag, " preempt"}, 32'(arb.preempt), 32'(p));
    if (|g) chk({tag, " gnt_idx"}, 32'(arb.gnt_idx), 32'(ix));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b0;
    arb.req = '0;
`ifdef RR_ARB_LOCK_EN
    arb.lock = 1'b0;
`endif
    #2 rst = 1'b1;
    #1;
    chk_out("reset", 4'b0000, 2'd0, 1'b0);
    chk("reset gnt_idx", 32'(arb.gnt_idx), 32'd0);
    step();
    rst = 1'b0;

    // {rst, req, expected gnt, expected idx, expected preempt}
    for (int i = 0; i < 5; i++) add(0, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, 4'b0100, 4'b0100, 2'd2, 0);
    add(0, 4'b0000, 4'b0000, 2'd0, 0);
    add(1, 4'b0000, 4'b0000, 2'd0, 0);
    // rotation 0,1,2,3,0 with each owner releasing after two cycles
    add(0, 4'b1111, 4'b0001, 2'd0, 0);
    add(0, 4'b1111, 4'b0001, 2'd0, 0);
    add(0, 4'b1110, 4'b0010, 2'd1, 0);
    add(0, 4'b1111, 4'b0010, 2'd1, 0);
    add(0, 4'b1101, 4'b0100, 2'd2, 0);
    add(0, 4'b1111, 4'b0100, 2'd2, 0);
    add(0, 4'b1011, 4'b1000, 2'd3, 0);
    add(0, 4'b1111, 4'b1000, 2'd3, 0);
    add(0, 4'b0111, 4'b0001, 2'd0, 0);
    add(0, 4'b0000, 4'b0000, 2'd0, 0);
    // timeout handover 0 -> 1 -> 0
    add(1, 4'b0000, 4'b0000, 2'd0, 0);
    for (int i = 0; i < 4; i++) add(0, 4'b0011, 4'b0001, 2'd0, 0);
    add(0, 4'b0011, 4'b0010, 2'd1, 1);
    for (int i = 0; i < 3; i++) add(0, 4'b0011, 4'b0010, 2'd1, 0);
    add(0, 4'b0011, 4'b0001, 2'd0, 1);
    for (int i = 0; i < 3; i++) add(0, 4'b0011, 4'b0001, 2'd0, 0);
    // owner drops exactly when the timeout would fire: plain release
    add(0, 4'b0010, 4'b0010, 2'd1, 0);
    // 3 -> 0 wrap; late arrival does not disturb the owner
    add(0, 4'b1000, 4'b1000, 2'd3, 0);
    add(0, 4'b1001, 4'b1000, 2'd3, 0);
    add(0, 4'b0001, 4'b0001, 2'd0, 0);
    add(0, 4'b0000, 4'b0000, 2'd0, 0);

    foreach (vecs[i]) begin
      rst     = vecs[i].rst;
      arb.req = vecs[i].req;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].preempt);
    end
    rst = 1'b0;

    // asynchronous reset while granted, then no grant on an edge with rst high
    arb.req = 4'b0100;
    step();
    chk_out("pre_rst", 4'b0100, 2'd2, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_out("async_rst", 4'b0000, 2'd0, 1'b0);
    step();
    chk_out("rst_edge", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    step();
    chk_out("post_rst", 4'b0100, 2'd2, 1'b0);
    arb.req = 4'b0000;
    step();
    chk_out("post_rst_idle", 4'b0000, 2'd0, 1'b0);

`ifdef RR_ARB_LOCK_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    arb.lock = 1'b1;
    arb.req  = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_out($sformatf("lock%0d", i), 4'b0001, 2'd0, 1'b0);
    end
    arb.lock = 1'b0;
    step();
    chk_out("unlock", 4'b0010, 2'd1, 1'b1);
    step();
    chk_out("unlock+1", 4'b0010, 2'd1, 1'b0);
    arb.req = 4'b0000;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
